// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch hazard control: forwarding select, stall, flush
//
// Purpose: resolves a conditional branch held in IF/ID. Picks the comparator
// operand sources, stalls the front end while an operand is still in flight,
// and redirects the PC / squashes IF/ID on a taken branch.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   IsBranch, IFID_Rs1/Rs2        branch in IF/ID and its source registers
//   IDEX_* / EXMEM_* / MEMWB_*    destination, write-enable and load flags of later stages
//   BranchCmp                     comparator result (1 = taken)
//   Ext_Stall                     global pipeline freeze
//   Ctrl_Mux_1/2_Branch           operand source: 00 regfile, 01 EXMEM ALU, 10 MEMWB mem data
//   Stall_Front, Bubble_IDEX      hold PC/IF/ID, inject NOP into ID/EX
//   Flush_IFID, PC_Sel_Branch     taken-branch redirect
//   Stall_Count, Taken_Count      saturating debug counters
module branch_hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IsBranch,
  input  logic [REG_AW-1:0] IFID_Rs1,
  input  logic [REG_AW-1:0] IFID_Rs2,
  input  logic [REG_AW-1:0] IDEX_Rd,
  input  logic              IDEX_RegWrite,
  input  logic              IDEX_MemRead,
  input  logic [REG_AW-1:0] EXMEM_Rd,
  input  logic              EXMEM_RegWrite,
  input  logic              EXMEM_MemRead,
  input  logic [REG_AW-1:0] MEMWB_Rd,
  input  logic              MEMWB_RegWrite,
  input  logic              BranchCmp,
  input  logic              Ext_Stall,
  output logic [1:0]        Ctrl_Mux_1_Branch,
  output logic [1:0]        Ctrl_Mux_2_Branch,
  output logic              Stall_Front,
  output logic              Bubble_IDEX,
  output logic              Flush_IFID,
  output logic              PC_Sel_Branch,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Taken_Count
);

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [1:0]         rem_q, rem_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

  logic               stall_int, bubble_int, flush_int, pcsel_int;
  logic [1:0]         need1, need2, need;
  logic [1:0]         fwd1, fwd2;

  // x0 never creates a dependency, whatever Rd an older stage reports.
  function automatic logic hit(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rd,
                               input logic we);
    return (rs != '0) && we && (rd == rs);
  endfunction

  function automatic logic [1:0] need_of(input logic [REG_AW-1:0] rs);
    if (hit(rs, IDEX_Rd, IDEX_RegWrite))
      return IDEX_MemRead ? 2'd2 : 2'd1;
    else if (hit(rs, EXMEM_Rd, EXMEM_RegWrite) && EXMEM_MemRead)
      return 2'd1;
    else
      return 2'd0;
  endfunction

  // The regfile does not bypass same-cycle writes, so a WB producer must be forwarded.
  function automatic logic [1:0] fwd_of(input logic [REG_AW-1:0] rs);
    if (hit(rs, EXMEM_Rd, EXMEM_RegWrite) && !EXMEM_MemRead)
      return 2'b01;
    else if (hit(rs, MEMWB_Rd, MEMWB_RegWrite))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    need1 = need_of(IFID_Rs1);
    need2 = need_of(IFID_Rs2);
    need  = (need1 > need2) ? need1 : need2;
    fwd1  = fwd_of(IFID_Rs1);
    fwd2  = fwd_of(IFID_Rs2);
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    stall_int  = 1'b0;
    bubble_int = 1'b0;
    flush_int  = 1'b0;
    pcsel_int  = 1'b0;
    case (state_q)
      IDLE: begin
        if (IsBranch) begin
          if (need != 2'd0) begin
            stall_int  = 1'b1;
            bubble_int = 1'b1;
            rem_d      = need - 2'd1;
            // A single-cycle stall stays in IDLE and re-evaluates next cycle.
            state_d    = (need > 2'd1) ? STALL : IDLE;
          end else if (BranchCmp) begin
            flush_int = 1'b1;
            pcsel_int = 1'b1;
            state_d   = FLUSH;
          end
        end
      end
      STALL: begin
        stall_int  = 1'b1;
        bubble_int = 1'b1;
        rem_d      = (rem_q == 2'd0) ? 2'd0 : rem_q - 2'd1;
        if (rem_q <= 2'd1)
          state_d = IDLE;
      end
      FLUSH: begin
        // Slot holds the squashed fall-through instruction; IsBranch is ignored.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (stall_int && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pcsel_int && !(&taken_cnt_q))
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else if (!Ext_Stall) begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // Ext_Stall holds the front end but must not bubble or redirect, since nothing advances.
  always_comb begin
    Stall_Front       = !rst && (Ext_Stall || stall_int);
    Bubble_IDEX       = !rst && !Ext_Stall && bubble_int;
    Flush_IFID        = !rst && !Ext_Stall && flush_int;
    PC_Sel_Branch     = !rst && !Ext_Stall && pcsel_int;
    Ctrl_Mux_1_Branch = 2'b00;
    Ctrl_Mux_2_Branch = 2'b00;
    if (!rst && (state_q == IDLE) && (need == 2'd0)) begin
      Ctrl_Mux_1_Branch = fwd1;
      Ctrl_Mux_2_Branch = fwd2;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Taken_Count = taken_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - directed self-checking bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          IsBranch;
  logic [4:0]    IFID_Rs1, IFID_Rs2;
  logic [4:0]    IDEX_Rd;
  logic          IDEX_RegWrite, IDEX_MemRead;
  logic [4:0]    EXMEM_Rd;
  logic          EXMEM_RegWrite, EXMEM_MemRead;
  logic [4:0]    MEMWB_Rd;
  logic          MEMWB_RegWrite;
  logic          BranchCmp;
  logic          Ext_Stall;
  logic [1:0]    Ctrl_Mux_1_Branch, Ctrl_Mux_2_Branch;
  logic          Stall_Front, Bubble_IDEX, Flush_IFID, PC_Sel_Branch;
  logic [CW-1:0] Stall_Count, Taken_Count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_hazard_ctrl #(.CNT_W(CW), .REG_AW(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .IsBranch          (IsBranch),
    .IFID_Rs1          (IFID_Rs1),
    .IFID_Rs2          (IFID_Rs2),
    .IDEX_Rd           (IDEX_Rd),
    .IDEX_RegWrite     (IDEX_RegWrite),
    .IDEX_MemRead      (IDEX_MemRead),
    .EXMEM_Rd          (EXMEM_Rd),
    .EXMEM_RegWrite    (EXMEM_RegWrite),
    .EXMEM_MemRead     (EXMEM_MemRead),
    .MEMWB_Rd          (MEMWB_Rd),
    .MEMWB_RegWrite    (MEMWB_RegWrite),
    .BranchCmp         (BranchCmp),
    .Ext_Stall         (Ext_Stall),
    .Ctrl_Mux_1_Branch (Ctrl_Mux_1_Branch),
    .Ctrl_Mux_2_Branch (Ctrl_Mux_2_Branch),
    .Stall_Front       (Stall_Front),
    .Bubble_IDEX       (Bubble_IDEX),
    .Flush_IFID        (Flush_IFID),
    .PC_Sel_Branch     (PC_Sel_Branch),
    .Stall_Count       (Stall_Count),
    .Taken_Count       (Taken_Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    IsBranch = 0; IFID_Rs1 = 0; IFID_Rs2 = 0;
    IDEX_Rd = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
    EXMEM_Rd = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0;
    MEMWB_Rd = 0; MEMWB_RegWrite = 0; BranchCmp = 0; Ext_Stall = 0;
  endtask

  // Step to the next falling edge; checks run 1ns later, away from the rising edge.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    next_cyc(); next_cyc();
    // Reset held with a hazard present: everything stays quiet.
    IsBranch = 1; IFID_Rs1 = 5; IDEX_Rd = 5; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    #1;
    chk("rst_stall_front", Stall_Front, 0);
    chk("rst_bubble", Bubble_IDEX, 0);

    // ---- Reset mid-STALL ----
    next_cyc(); rst = 0;
    IsBranch = 1; IFID_Rs1 = 5; IFID_Rs2 = 6;
    IDEX_Rd = 5; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    #1;
    chk("rstmid_c1_stall", Stall_Front, 1);
    chk("rstmid_c1_bubble", Bubble_IDEX, 1);
    next_cyc();
    #1;
    chk("rstmid_c2_stall", Stall_Front, 1);
    rst = 1;
    next_cyc();
    rst = 0; clear_in();
    IsBranch = 1; IFID_Rs1 = 1; IFID_Rs2 = 2; BranchCmp = 0;
    #1;
    chk("rstmid_stall_front", Stall_Front, 0);
    chk("rstmid_bubble", Bubble_IDEX, 0);
    chk("rstmid_flush", Flush_IFID, 0);
    chk("rstmid_pcsel", PC_Sel_Branch, 0);
    chk("rstmid_mux1", Ctrl_Mux_1_Branch, 0);
    chk("rstmid_stall_cnt", Stall_Count, 0);
    chk("rstmid_taken_cnt", Taken_Count, 0);

    // ---- Load-use: lw x5 ; beq x5,x6 ----
    next_cyc(); clear_in();
    IsBranch = 1; IFID_Rs1 = 5; IFID_Rs2 = 6; BranchCmp = 1;
    IDEX_Rd = 5; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    #1;
    chk("lu_c1_stall", Stall_Front, 1);
    chk("lu_c1_bubble", Bubble_IDEX, 1);
    chk("lu_c1_flush", Flush_IFID, 0);
    chk("lu_c1_pcsel", PC_Sel_Branch, 0);
    next_cyc();
    IDEX_Rd = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
    EXMEM_Rd = 5; EXMEM_RegWrite = 1; EXMEM_MemRead = 1;
    #1;
    chk("lu_c2_stall", Stall_Front, 1);
    chk("lu_c2_bubble", Bubble_IDEX, 1);
    chk("lu_c2_flush", Flush_IFID, 0);
    next_cyc();
    EXMEM_Rd = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0;
    MEMWB_Rd = 5; MEMWB_RegWrite = 1;
    #1;
    chk("lu_c3_stall", Stall_Front, 0);
    chk("lu_c3_mux1", Ctrl_Mux_1_Branch, 2'b10);
    chk("lu_c3_mux2", Ctrl_Mux_2_Branch, 2'b00);
    chk("lu_c3_flush", Flush_IFID, 1);
    chk("lu_c3_pcsel", PC_Sel_Branch, 1);
    chk("lu_stall_cnt", Stall_Count, 2);
    next_cyc();
    #1;
    chk("lu_flushst_flush", Flush_IFID, 0);
    chk("lu_flushst_pcsel", PC_Sel_Branch, 0);
    chk("lu_flushst_stall", Stall_Front, 0);
    chk("lu_flushst_mux1", Ctrl_Mux_1_Branch, 0);
    chk("lu_taken_cnt", Taken_Count, 1);

    // ---- ALU dependency: add x7 ; bne x7,x0 ----
    next_cyc(); clear_in();
    IsBranch = 1; IFID_Rs1 = 7; IFID_Rs2 = 0; BranchCmp = 0;
    IDEX_Rd = 7; IDEX_RegWrite = 1;
    #1;
    chk("alu_c1_stall", Stall_Front, 1);
    chk("alu_c1_bubble", Bubble_IDEX, 1);
    chk("alu_c1_mux1", Ctrl_Mux_1_Branch, 0);
    next_cyc();
    IDEX_Rd = 0; IDEX_RegWrite = 0;
    EXMEM_Rd = 7; EXMEM_RegWrite = 1;
    #1;
    chk("alu_c2_stall", Stall_Front, 0);
    chk("alu_c2_mux1", Ctrl_Mux_1_Branch, 2'b01);
    chk("alu_c2_mux2", Ctrl_Mux_2_Branch, 2'b00);
    chk("alu_c2_flush", Flush_IFID, 0);
    chk("alu_c2_pcsel", PC_Sel_Branch, 0);
    chk("alu_stall_cnt", Stall_Count, 3);

    // ---- Forwarding priority and x0 ----
    next_cyc(); clear_in();
    IsBranch = 1; IFID_Rs1 = 3; IFID_Rs2 = 3;
    EXMEM_Rd = 3; EXMEM_RegWrite = 1; MEMWB_Rd = 3; MEMWB_RegWrite = 1;
    #1;
    chk("prio_mux1", Ctrl_Mux_1_Branch, 2'b01);
    chk("prio_mux2", Ctrl_Mux_2_Branch, 2'b01);
    chk("prio_stall", Stall_Front, 0);
    next_cyc(); clear_in();
    IsBranch = 1; IFID_Rs1 = 0; IFID_Rs2 = 0;
    IDEX_Rd = 0; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    EXMEM_Rd = 0; EXMEM_RegWrite = 1; MEMWB_Rd = 0; MEMWB_RegWrite = 1;
    #1;
    chk("x0_mux1", Ctrl_Mux_1_Branch, 0);
    chk("x0_mux2", Ctrl_Mux_2_Branch, 0);
    chk("x0_stall", Stall_Front, 0);
    next_cyc(); clear_in();
    IsBranch = 1; IFID_Rs1 = 9; IFID_Rs2 = 4; MEMWB_Rd = 4; MEMWB_RegWrite = 1;
    #1;
    chk("wb_mux1", Ctrl_Mux_1_Branch, 0);
    chk("wb_mux2", Ctrl_Mux_2_Branch, 2'b10);
    chk("fwd_stall_cnt", Stall_Count, 3);

    // ---- Ext_Stall inside a 2-cycle load stall ----
    next_cyc(); clear_in(); rst = 1;
    next_cyc(); rst = 0;
    IsBranch = 1; IFID_Rs1 = 5; IFID_Rs2 = 6; BranchCmp = 1;
    IDEX_Rd = 5; IDEX_RegWrite = 1; IDEX_MemRead = 1;
    #1;
    chk("ext_c1_stall", Stall_Front, 1);
    chk("ext_c1_bubble", Bubble_IDEX, 1);
    next_cyc();
    IDEX_Rd = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
    EXMEM_Rd = 5; EXMEM_RegWrite = 1; EXMEM_MemRead = 1;
    Ext_Stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ext_frz_stall", Stall_Front, 1);
      chk("ext_frz_bubble", Bubble_IDEX, 0);
      chk("ext_frz_flush", Flush_IFID, 0);
      next_cyc();
    end
    #1;
    chk("ext_frz_stall_cnt", Stall_Count, 1);
    Ext_Stall = 0;
    #1;
    chk("ext_rel_stall", Stall_Front, 1);
    chk("ext_rel_bubble", Bubble_IDEX, 1);
    chk("ext_rel_flush", Flush_IFID, 0);
    next_cyc();
    EXMEM_Rd = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0;
    MEMWB_Rd = 5; MEMWB_RegWrite = 1;
    Ext_Stall = 1;
    #1;
    chk("ext_idle_stall", Stall_Front, 1);
    chk("ext_idle_flush", Flush_IFID, 0);
    chk("ext_idle_pcsel", PC_Sel_Branch, 0);
    chk("ext_idle_mux1", Ctrl_Mux_1_Branch, 2'b10);
    chk("ext_stall_cnt", Stall_Count, 2);
    next_cyc();
    Ext_Stall = 0;
    #1;
    chk("ext_go_flush", Flush_IFID, 1);
    chk("ext_go_pcsel", PC_Sel_Branch, 1);
    chk("ext_go_stall", Stall_Front, 0);
    next_cyc();
    #1;
    chk("ext_taken_cnt", Taken_Count, 1);
    chk("ext_stall_cnt2", Stall_Count, 2);

    // ---- Saturation ----
    clear_in(); rst = 1;
    next_cyc(); rst = 0;
    IsBranch = 1; IFID_Rs1 = 7; IDEX_Rd = 7; IDEX_RegWrite = 1;
    repeat (100) next_cyc();
    #1;
    chk("sat_stall_100", Stall_Count, 100);
    repeat (160) next_cyc();
    #1;
    chk("sat_stall_max", Stall_Count, 255);
    chk("sat_stall_front", Stall_Front, 1);
    IDEX_Rd = 0; IDEX_RegWrite = 0; BranchCmp = 1;
    repeat (20) next_cyc();
    #1;
    chk("sat_taken_10", Taken_Count, 10);
    repeat (580) next_cyc();
    #1;
    chk("sat_taken_max", Taken_Count, 255);
    chk("sat_taken_pcsel", PC_Sel_Branch, 1);
    chk("sat_stall_hold", Stall_Count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
Sequences ID-stage branch resolution in the RV32 five-stage pipeline. For a branch in IF/ID it selects the forwarding source for each branch-comparator operand, stalls the front end while an operand is still being produced, and flushes IF/ID when the branch is taken. It also keeps saturating stall and taken-branch counters for debug.

Parameters:
CNT_W, 16, width of the performance counters
REG_AW, 5, register address width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
IsBranch  input  1  IF/ID holds a conditional branch
IFID_Rs1  input  REG_AW  branch source register 1
IFID_Rs2  input  REG_AW  branch source register 2
IDEX_Rd  input  REG_AW  destination register of the instruction in EX
IDEX_RegWrite  input  1  EX instruction writes a register
IDEX_MemRead  input  1  EX instruction is a load
EXMEM_Rd  input  REG_AW  destination register of the instruction in MEM
EXMEM_RegWrite  input  1  MEM instruction writes a register
EXMEM_MemRead  input  1  MEM instruction is a load
MEMWB_Rd  input  REG_AW  destination register of the instruction in WB
MEMWB_RegWrite  input  1  WB instruction writes a register
BranchCmp  input  1  comparator result (1 = branch taken)
Ext_Stall  input  1  global pipeline freeze (memory wait)
Ctrl_Mux_1_Branch  output  2  operand 1 source: 00 regfile, 01 EXMEM_Alu_Data, 10 MEMWB_Mem_Data
Ctrl_Mux_2_Branch  output  2  operand 2 source, same encoding
Stall_Front  output  1  hold PC and IF/ID
Bubble_IDEX  output  1  insert a NOP into ID/EX
Flush_IFID  output  1  squash IF/ID
PC_Sel_Branch  output  1  load the branch target into the PC
Stall_Count  output  CNT_W  number of stall cycles, saturating
Taken_Count  output  CNT_W  number of taken branches, saturating

Behaviour:
- Reset: FSM goes to IDLE. All single-bit outputs are 0, mux selects are 00 and both counters are 0. Reset aborts any stall or flush in progress.
- Match rule for operand X: rsX != 0 and the stage's RegWrite = 1 and the stage's Rd = rsX.
- Required stalls per operand:
  - IDEX match with MemRead: 2.
  - IDEX match without MemRead: 1.
  - EXMEM match with MemRead: 1.
  - Otherwise: 0.
- need = max over both operands.
- Forward select per operand (evaluated only when need = 0):
  - EXMEM non-load match: 01.
  - Else MEMWB match: 10.
  - Else: 00.
  - EXMEM has priority over MEMWB. The regfile does not bypass writes internally.
- Mux selects are combinational and are valid only in IDLE with need = 0. They are 00 in all other cases.
- FSM states: IDLE, STALL, FLUSH. A 2-bit remaining-stall counter holds the count.
- IDLE, IsBranch=1, need>0:
  - Assert Stall_Front and Bubble_IDEX combinationally in the same cycle.
  - Load the counter with need-1.
  - Go to STALL if need-1 > 0. Otherwise stay in IDLE and re-evaluate next cycle.
- STALL:
  - Stall_Front = Bubble_IDEX = 1. Hazards are not re-evaluated.
  - Decrement the counter; at 0 return to IDLE.
  - A 2-cycle load stall is therefore exactly 2 cycles. IDLE then re-evaluates and resolves via forwarding.
- IDLE, IsBranch=1, need=0:
  - If BranchCmp=1: assert Flush_IFID and PC_Sel_Branch for one cycle and go to FLUSH.
  - If BranchCmp=0: no action.
- FLUSH: lasts one cycle. IsBranch is ignored because the slot holds a squashed instruction. All control outputs are 0. Returns to IDLE.
- Ext_Stall=1 freezes all state (FSM, stall counter, perf counters). Stall_Front is forced to 1. Bubble_IDEX, Flush_IFID and PC_Sel_Branch are forced to 0. Mux selects keep their evaluated values.
- Counters:
  - Stall_Count increments on every cycle with Stall_Front=1 caused by this block. Cycles where Stall_Front comes only from Ext_Stall do not count.
  - Taken_Count increments on every cycle with PC_Sel_Branch=1.
  - Both saturate at all-ones and do not wrap.
- Only Flush_IFID and PC_Sel_Branch are taken-branch outputs. A branch is never resolved in a cycle where a stall is asserted.

Test Plan:
- Reset mid-STALL: load x5 in EX, branch on x5; assert rst in the second stall cycle -> next cycle state IDLE, all outputs 0, Stall_Count=0.
- Load-use: `lw x5` in EX, `beq x5,x6` in ID, BranchCmp=1 -> Stall_Front/Bubble_IDEX high for exactly 2 cycles. Third cycle: Ctrl_Mux_1_Branch=10, Flush_IFID=PC_Sel_Branch=1. Stall_Count=2, Taken_Count=1.
- ALU dependency: `add x7` in EX, `bne x7,x0` -> 1 stall cycle, then Ctrl_Mux_1_Branch=01, Ctrl_Mux_2_Branch=00. With BranchCmp=0 there is no flush.
- Forwarding priority: EXMEM (non-load) and MEMWB both write x3, branch on x3,x3 -> both selects 01, no stall. With rs=x0 matching an Rd of 0 -> selects 00, no stall.
- Ext_Stall during STALL: 3 cycles of Ext_Stall in the middle of a 2-cycle load stall -> 5 total front-end stall cycles, Stall_Count=2, no flush until release.
- Saturation: preload the counters near max via 2^CNT_W taken branches -> Taken_Count holds at all-ones.
